// File: rtl/keccak_pkg.sv
// Shared constants and types for the SHA-3 / SHAKE padding datapath.
package keccak_pkg;

  localparam int unsigned LANE_W = 64;

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

  // Rate in 64-bit lanes for each mode.
  localparam int unsigned RATE_SHA3_224 = 18;
  localparam int unsigned RATE_SHA3_256 = 17;
  localparam int unsigned RATE_SHA3_384 = 13;
  localparam int unsigned RATE_SHA3_512 = 9;
  localparam int unsigned RATE_SHAKE128 = 21;
  localparam int unsigned RATE_SHAKE256 = 17;

  typedef enum logic [1:0] {
    ACCEPT,
    FULL,
    EXTRA
  } pad_state_t;

endpackage

// File: rtl/sha3_lane_pad.sv
// Combinational per-lane padding: keeps the valid message bytes, drops the
// domain-separation suffix right after them and zeroes the remainder.
// A byte count of 8..15 means the whole lane is message data.
module sha3_lane_pad
  import keccak_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic [3:0]        byte_num,
  input  logic [7:0]        suffix,
  output logic [LANE_W-1:0] padded,
  output logic              whole
);

  // Byte-wise select between message byte, suffix and zero (byte 0 at MSBs).
  always_comb begin
    whole  = byte_num[3];
    padded = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (whole || (4'(b) < byte_num)) begin
        padded[LANE_W-1-8*b -: 8] = lane[LANE_W-1-8*b -: 8];
      end else if (4'(b) == byte_num) begin
        padded[LANE_W-1-8*b -: 8] = suffix;
      end
    end
  end

endmodule

// File: rtl/sha3_block_padder.sv
// Collects 64-bit message lanes into a rate-sized block and applies the
// SHA-3 multi-rate padding (suffix ... 0x80) to the final block of a message.
module sha3_block_padder
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_WORDS = 17,
  parameter logic [7:0]  SUFFIX     = SUFFIX_SHA3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [LANE_W-1:0]            in_data,
  input  logic [3:0]                   in_byte_num,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANE_W*RATE_WORDS-1:0] out_block,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int unsigned BLK_W = LANE_W * RATE_WORDS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATE_WORDS - 1);

  pad_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_next;
  logic [BLK_W-1:0]  block_q;
  logic [BLK_W-1:0]  block_d;
  logic              extra_q;
  logic [LANE_W-1:0] pad_lane;
  logic              pad_whole;
  logic              at_last;
  logic              accept;
  logic              done;

  sha3_lane_pad u_lane_pad (
    .lane     (in_data),
    .byte_num (in_byte_num),
    .suffix   (SUFFIX),
    .padded   (pad_lane),
    .whole    (pad_whole)
  );

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q != ACCEPT);
  assign out_block = block_q;

  assign accept   = in_valid && (state_q == ACCEPT);
  assign done     = out_ready && (state_q != ACCEPT);
  assign at_last  = (idx_q == IDX_LAST);
  assign idx_next = idx_q + IDX_W'(1);

  // Next block contents: write the accepted lane, pad the tail on the last
  // lane, or clear / load the pad-only block on a completed handshake.
  always_comb begin
    block_d = block_q;
    if (accept) begin
      for (int unsigned i = 0; i < RATE_WORDS; i++) begin
        if (IDX_W'(i) == idx_q) begin
          block_d[BLK_W-1-LANE_W*i -: LANE_W] = in_last ? pad_lane : in_data;
        end else if (in_last && (IDX_W'(i) > idx_q)) begin
          block_d[BLK_W-1-LANE_W*i -: LANE_W] =
            (pad_whole && (IDX_W'(i) == idx_next)) ? {SUFFIX, {(LANE_W-8){1'b0}}} : '0;
        end
      end
      // A whole last lane in the final slot leaves no room; padding moves
      // to a separate all-pad block instead.
      if (in_last && !(pad_whole && at_last)) begin
        block_d[7:0] = block_d[7:0] | 8'h80;
      end
    end else if (done) begin
      block_d = '0;
      if ((state_q == FULL) && extra_q) begin
        block_d[BLK_W-1 -: LANE_W] = {SUFFIX, {(LANE_W-8){1'b0}}};
        block_d[7:0] = block_d[7:0] | 8'h80;
      end
    end
  end

  // Control FSM, lane index and registered block / out_last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ACCEPT;
      idx_q    <= '0;
      block_q  <= '0;
      extra_q  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      block_q <= block_d;
      case (state_q)
        ACCEPT: begin
          if (in_valid) begin
            idx_q <= idx_next;
            if (in_last) begin
              state_q  <= FULL;
              out_last <= !(pad_whole && at_last);
              extra_q  <= pad_whole && at_last;
            end else if (at_last) begin
              state_q  <= FULL;
              out_last <= 1'b0;
              extra_q  <= 1'b0;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            idx_q <= '0;
            if (extra_q) begin
              state_q  <= EXTRA;
              out_last <= 1'b1;
              extra_q  <= 1'b0;
            end else begin
              state_q  <= ACCEPT;
              out_last <= 1'b0;
            end
          end
        end
        EXTRA: begin
          if (out_ready) begin
            idx_q    <= '0;
            state_q  <= ACCEPT;
            out_last <= 1'b0;
          end
        end
        default: begin
          state_q  <= ACCEPT;
          idx_q    <= '0;
          out_last <= 1'b0;
          extra_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_block_padder.sv
// Self-checking bench for sha3_block_padder (RATE_WORDS=17, SHA3 suffix).
// Expected blocks come from a byte-level model: message bytes, suffix,
// zero fill to a rate multiple, 0x80 OR'd into the very last byte.
module tb_sha3_block_padder;

  localparam int unsigned R   = 17;
  localparam int unsigned RB  = R * 8;
  localparam int unsigned BW  = 64 * R;
  localparam logic [7:0]  SFX = 8'h06;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   in_data = '0;
  logic [3:0]    in_byte_num = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] out_block;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0]   lanes[$];
  int            last_n;
  byte unsigned  exp_bytes[$];
  int            n_blocks;
  logic [BW-1:0] got_blk[$];
  logic          got_last[$];

  always #5 clk = ~clk;

  sha3_block_padder #(.RATE_WORDS(R), .SUFFIX(SFX)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_byte_num (in_byte_num),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_block   (out_block),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  function automatic logic [63:0] slot(input logic [BW-1:0] v, input int s);
    return v[BW-1-64*s -: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    int s;
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      s = 0;
      while (s < R - 1 && slot(obs, s) === slot(exp, s)) s++;
      $error("FAIL %s slot %0d: got %h expected %h", tag, s, slot(obs, s), slot(exp, s));
    end
  endtask

  function automatic void build_expected();
    int nb;
    logic [63:0] w;
    exp_bytes.delete();
    for (int k = 0; k < lanes.size(); k++) begin
      w  = lanes[k];
      nb = (k == lanes.size() - 1) ? ((last_n > 8) ? 8 : last_n) : 8;
      for (int b = 0; b < nb; b++) exp_bytes.push_back(w[63-8*b -: 8]);
    end
    exp_bytes.push_back(SFX);
    while (exp_bytes.size() % RB != 0) exp_bytes.push_back(8'h00);
    exp_bytes[exp_bytes.size()-1] = exp_bytes[exp_bytes.size()-1] | 8'h80;
    n_blocks = exp_bytes.size() / RB;
  endfunction

  function automatic logic [BW-1:0] exp_block(input int j);
    logic [BW-1:0] v;
    v = '0;
    for (int b = 0; b < RB; b++) v[BW-1-8*b -: 8] = exp_bytes[j*RB + b];
    return v;
  endfunction

  task automatic drive_lane(input logic [63:0] d, input logic last, input logic [3:0] n);
    int t;
    t = 0;
    @(negedge clk);
    in_data = d; in_last = last; in_byte_num = n; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic recv_block(input int j, input bit stall);
    int t;
    logic [BW-1:0] e;
    e = exp_block(j);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (out_valid !== 1'b1) begin
      chk("out_valid_wait", 64'(out_valid), 64'd1);
      return;
    end
    chk_blk("block", out_block, e);
    chk("out_last", 64'(out_last), 64'(j == n_blocks - 1));
    chk("in_ready_blocked", 64'(in_ready), 64'd0);
    got_blk.push_back(out_block);
    got_last.push_back(out_last);
    if (stall) begin
      repeat (10) begin
        @(negedge clk);
        chk_blk("stall_block_stable", out_block, e);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_msg(input int stall_blk);
    int j;
    int nl;
    logic is_last;
    bit blk_done;
    j  = 0;
    nl = lanes.size();
    got_blk.delete();
    got_last.delete();
    build_expected();
    for (int k = 0; k < nl; k++) begin
      is_last = (k == nl - 1);
      drive_lane(lanes[k], is_last, is_last ? 4'(last_n) : 4'($urandom));
      blk_done = is_last || (((k + 1) * 8) % RB == 0);
      chk("out_valid_latency", 64'(out_valid), 64'(blk_done));
      if (blk_done) begin
        recv_block(j, j == stall_blk);
        j++;
      end
    end
    while (j < n_blocks) begin
      recv_block(j, 1'b0);
      j++;
    end
    @(negedge clk);
    chk("back_to_accept", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  function automatic void rand_lanes(input int n);
    lanes.delete();
    for (int k = 0; k < n; k++) lanes.push_back({$urandom, $urandom});
  endfunction

  initial begin
    logic [BW-1:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk_blk("rst_block", out_block, '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single last lane, n=0
    rand_lanes(1); last_n = 0;
    run_msg(-1);
    if (got_blk.size() > 0) begin
      b = got_blk[0];
      chk("n0_slot0", slot(b, 0), 64'h0600000000000000);
      chk("n0_slot8", slot(b, 8), 64'h0);
      chk("n0_slot16", slot(b, 16), 64'h80);
    end

    // 17 full lanes then last lane n=3
    rand_lanes(17); lanes.push_back(64'hAABBCCDDEEFF0011); last_n = 3;
    run_msg(-1);
    if (got_blk.size() > 1) begin
      chk("n3_blk1_last", 64'(got_last[0]), 64'd0);
      b = got_blk[1];
      chk("n3_slot0", slot(b, 0), 64'hAABBCC0600000000);
      chk("n3_slot16", slot(b, 16), 64'h80);
    end

    // Last lane in final slot, n=7
    rand_lanes(17); last_n = 7;
    run_msg(-1);
    if (got_blk.size() > 0) begin
      b = got_blk[0];
      chk("n7_last_byte", 64'(b[7:0]), 64'h86);
    end

    // Last lane in final slot, n=8 -> extra pad block
    rand_lanes(17); last_n = 8;
    run_msg(-1);
    chk("n8_block_count", 64'(got_blk.size()), 64'd2);
    if (got_blk.size() > 1) begin
      chk("n8_blk0_last", 64'(got_last[0]), 64'd0);
      b = got_blk[1];
      chk("n8_extra_slot0", slot(b, 0), 64'h0600000000000000);
      chk("n8_extra_slot16", slot(b, 16), 64'h80);
      chk("n8_extra_last", 64'(got_last[1]), 64'd1);
    end

    // Whole last lane mid-block, count 13 treated as 8
    rand_lanes(5); last_n = 13;
    run_msg(-1);

    // Output back-pressure for 10 cycles
    rand_lanes(18); last_n = 2;
    run_msg(0);

    // Reset in the middle of a block
    rand_lanes(5);
    for (int k = 0; k < 5; k++) drive_lane(lanes[k], 1'b0, 4'd0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk_blk("mid_rst_block", out_block, '0);
    @(negedge clk);
    reset_n = 1'b1;
    rand_lanes(3); last_n = 4;
    run_msg(-1);

    // Random messages
    for (int m = 0; m < 8; m++) begin
      rand_lanes($urandom_range(1, 40));
      last_n = $urandom_range(0, 15);
      run_msg((m == 3) ? 0 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sha3_block_padder.md
SHA3_BLOCK_PADDER -- requirements
Module: sha3_block_padder

Interface
REQ-001 SHALL have parameter RATE_WORDS, default 17, meaning the rate in 64-bit lanes (17=SHA3-256, 18=SHA3-224, 13=SHA3-384, 9=SHA3-512, 21=SHAKE128).
REQ-002 SHALL have parameter SUFFIX, default 8'h06, meaning the domain-separation byte (8'h06 SHA3, 8'h1F SHAKE).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  64  message lane; byte 0 = [63:56], byte 7 = [7:0].
REQ-006 in_byte_num  in  4  valid bytes in in_data when in_last=1 (0..8); ignored when in_last=0.
REQ-007 in_last  in  1  marks final message lane.
REQ-008 in_valid / in_ready  in / out  1 each  input handshake; transfer when both high.
REQ-009 out_block  out  64*RATE_WORDS  padded block; lane 0 at MSBs.
REQ-010 out_last  out  1  out_block is the final block of the message.
REQ-011 out_valid / out_ready  out / in  1 each  output handshake; transfer when both high.

Function
REQ-012 SHALL implement a state machine with states ACCEPT, FULL, EXTRA; reset state ACCEPT.
REQ-013 in_ready SHALL be 1 only in ACCEPT; out_valid SHALL be 1 only in FULL and EXTRA.
REQ-014 A lane index counter (0..RATE_WORDS-1) SHALL write each accepted lane into block slot index, then increment.
REQ-015 Non-last lane accepted at index RATE_WORDS-1: SHALL go to FULL with out_last=0 on the next cycle.
REQ-016 Last lane with n=in_byte_num<8: SHALL keep bytes 0..n-1, place SUFFIX at byte n, zero bytes n+1..7 and all later slots, OR 8'h80 into byte 7 of slot RATE_WORDS-1, all in the accept cycle; next state FULL, out_last=1.
REQ-017 Last lane at slot RATE_WORDS-1 with n=7: SUFFIX|8'h80 SHALL occupy [7:0] (8'h86 for SHA3).
REQ-018 Last lane with n=8 (values 9..15 SHALL be treated as 8) at index<RATE_WORDS-1: lane stored whole, SUFFIX placed at byte 0 of slot index+1, later slots zeroed, 8'h80 OR'd into final byte; next state FULL, out_last=1.
REQ-019 Last lane with n=8 at index RATE_WORDS-1: SHALL go to FULL with out_last=0, then after the FULL handshake to EXTRA presenting an all-pad block (slot 0 = {SUFFIX,56'h0}, zeros, slot RATE_WORDS-1 [7:0] = 8'h80), out_last=1.
REQ-020 out_block and out_last SHALL be stable from out_valid rise until the handshake.
REQ-021 FULL/EXTRA handshake SHALL clear the block register, reset index to 0, and return to ACCEPT (FULL->EXTRA in the REQ-019 case).
REQ-022 Latency: out_valid SHALL rise exactly one cycle after the completing lane is accepted; no lane is accepted while out_valid=1.
REQ-023 Sustained throughput SHALL be RATE_WORDS lanes per RATE_WORDS+1 cycles with out_ready held high.

Reset
REQ-024 reset_n low SHALL asynchronously force state ACCEPT, index 0, block register 0, out_valid 0, out_last 0, in_ready 1 after release.
REQ-025 Reset mid-block SHALL discard partial data; the first lane after release lands in slot 0.

Structure
REQ-026 keccak_pkg SHALL hold the state enum, LANE_W=64, SUFFIX_SHA3=8'h06, SUFFIX_SHAKE=8'h1F and the rate constants per mode.
REQ-027 Per-lane padding (lane, byte count, suffix -> padded lane) SHALL be a combinational sub-module sha3_lane_pad.

Verification (RATE_WORDS=17, SUFFIX=8'h06)
REQ-028 Single last lane n=0 -> out_block slot0=64'h0600000000000000, slots1..15=0, slot16=64'h80, out_last=1.
REQ-029 17 full lanes then one last lane n=3 data 64'hAABBCC... -> block1 out_last=0; block2 slot0=64'hAABBCC0600000000, slot16=64'h80.
REQ-030 Last lane at slot16 with n=7 -> slot16[7:0]=8'h86; n=8 -> block out_last=0 followed by EXTRA block slot0=64'h0600000000000000, slot16=64'h80, out_last=1.
REQ-031 out_ready held low 10 cycles in FULL -> in_ready=0 and out_block unchanged throughout; handshake then returns to ACCEPT.
REQ-032 reset_n pulsed low after 5 lanes -> outputs cleared immediately; next message pads from slot 0 correctly.
